vending_ctrl: RTL and testbench

Vending-machine transaction controller sitting directly downstream of the 50 MHz→1 Hz clock divider. It consumes the divider's slow square wave as a seconds time base, edge-detected in the 50 MHz domain and never used as a clock. It accumulates coin credit, dispenses when credit reaches the price, returns change, and refunds on cancel or inactivity.

---
 rtl/vending_pkg.sv | 17 +
 rtl/vending_ctrl_tick_edge.sv | 13 +
 rtl/vending_ctrl.sv | 110 +++++++++++
 tb/tb_vending_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// vending_pkg: state encoding, coin codes and coin valuation shared by vending_ctrl
package vending_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, REFUND} state_t;
  localparam logic [1:0] COIN_1 = 2'd0;
  localparam logic [1:0] COIN_2 = 2'd1;
  localparam logic [1:0] COIN_5 = 2'd2;
  localparam logic [1:0] COIN_10 = 2'd3;
  function automatic logic [3:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_1: return 4'd1;
      COIN_2: return 4'd2;
      COIN_5: return 4'd5;
      COIN_10: return 4'd10;
      default: return 4'd0;
    endcase
  endfunction
endpackage

// File: rtl/vending_ctrl_tick_edge.sv
// tick_edge: one-cycle sec_tick pulse per rising edge of the divider's 1 Hz square wave
module tick_edge (
  input  logic clk_in,
  input  logic rst,
  input  logic tick_in,
  output logic sec_tick
);
  logic tick_q;
  always_ff @(posedge clk_in or negedge rst)
    if (!rst) tick_q <= 1'b0;
    else tick_q <= tick_in;
  assign sec_tick = tick_in & ~tick_q;
endmodule

// File: rtl/vending_ctrl.sv
// vending_ctrl: coin credit, dispense with change, cancel refund.
// Define VEND_TIMEOUT_EN to build the inactivity auto-refund in COLLECT.
module vending_ctrl
  import vending_pkg::*;
#(
  parameter int PRICE      = 15,
  parameter int MAX_CREDIT = 31,
  parameter int CREDIT_W   = 5,
  parameter int TIMEOUT_S  = 10,
  parameter int DISPENSE_S = 2
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                tick_in,
  input  logic                coin_valid,
  input  logic [1:0]          coin_code,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic                coin_reject,
  output logic                busy
);
  localparam int CNT_W = $clog2((TIMEOUT_S > DISPENSE_S ? TIMEOUT_S : DISPENSE_S) + 1);
  localparam logic [CREDIT_W:0] MAX_SUM = (CREDIT_W + 1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CNT_W-1:0] DSP_LAST = CNT_W'(DISPENSE_S - 1);
`ifdef VEND_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_S - 1);
`endif
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [CREDIT_W-1:0] chg;
  logic [CREDIT_W:0] sum;
  logic sec_tick, coin_ok;
  tick_edge u_tick (
    .clk_in  (clk_in),
    .rst     (rst),
    .tick_in (tick_in),
    .sec_tick(sec_tick)
  );
  always_comb begin
    sum = {1'b0, credit} + (CREDIT_W + 1)'(coin_value(coin_code));
    coin_ok = coin_valid && (sum <= MAX_SUM);
  end
  // Any coin not explicitly accepted below is reported as rejected.
  always_ff @(posedge clk_in or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      chg <= '0;
      credit <= '0;
      dispense <= 1'b0;
      change_valid <= 1'b0;
      change_amt <= '0;
      coin_reject <= 1'b0;
      busy <= 1'b0;
    end else begin
      change_valid <= 1'b0;
      coin_reject <= coin_valid;
      case (state)
        IDLE:
          if (coin_ok) begin
            state <= COLLECT;
            busy <= 1'b1;
            credit <= sum[CREDIT_W-1:0];
            cnt <= '0;
            coin_reject <= 1'b0;
          end
        COLLECT:
          if (credit >= PRICE_C) begin
            state <= DISPENSE;
            dispense <= 1'b1;
            chg <= credit - PRICE_C;
            cnt <= '0;
          end else if (cancel) state <= REFUND;
          else if (coin_valid) begin
            coin_reject <= !coin_ok;
            if (coin_ok) credit <= sum[CREDIT_W-1:0];
            cnt <= '0;
          end
`ifdef VEND_TIMEOUT_EN
          else if (sec_tick) begin
            if (cnt == TMO_LAST) state <= REFUND;
            cnt <= cnt + CNT_W'(1);
          end
`endif
        DISPENSE:
          if (sec_tick) begin
            if (cnt == DSP_LAST) begin
              state <= IDLE;
              busy <= 1'b0;
              dispense <= 1'b0;
              credit <= '0;
              change_valid <= chg != '0;
              change_amt <= chg;
            end else cnt <= cnt + CNT_W'(1);
          end
        REFUND: begin
          state <= IDLE;
          busy <= 1'b0;
          change_valid <= 1'b1;
          change_amt <= credit;
          credit <= '0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_vending_ctrl.sv
// tb_vending_ctrl: directed and randomized checks of vending_ctrl against a transaction-level credit model
module tb_vending_ctrl;
  localparam int PRICE = 15;
  logic clk_in = 1'b0;
  logic rst = 1'b1;
  logic tick_in = 1'b0;
  logic coin_valid = 1'b0, cancel = 1'b0;
  logic [1:0] coin_code = 2'd0;
  logic [4:0] credit, change_amt;
  logic dispense, change_valid, coin_reject, busy;
  logic s_coin_valid = 1'b0, s_cancel = 1'b0;
  logic [1:0] s_coin_code = 2'd0;
  logic [4:0] s_credit, s_change_amt;
  logic s_dispense, s_change_valid, s_coin_reject, s_busy;
  int checks = 0;
  int failures = 0;
  int vals[4] = '{1, 2, 5, 10};
  int total, n;
  logic [1:0] c;

  vending_ctrl u_dut (
    .clk_in(clk_in), .rst(rst), .tick_in(tick_in), .coin_valid(coin_valid),
    .coin_code(coin_code), .cancel(cancel), .credit(credit), .dispense(dispense),
    .change_valid(change_valid), .change_amt(change_amt), .coin_reject(coin_reject), .busy(busy)
  );
  vending_ctrl #(.MAX_CREDIT(20)) u_sat (
    .clk_in(clk_in), .rst(rst), .tick_in(tick_in), .coin_valid(s_coin_valid),
    .coin_code(s_coin_code), .cancel(s_cancel), .credit(s_credit), .dispense(s_dispense),
    .change_valid(s_change_valid), .change_amt(s_change_amt), .coin_reject(s_coin_reject), .busy(s_busy)
  );

  always #5 clk_in = ~clk_in;
  always #40 tick_in = ~tick_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge clk_in);
    #1;
  endtask

  task automatic coin(input logic [1:0] code);
    coin_valid = 1'b1;
    coin_code = code;
    cyc(1);
    coin_valid = 1'b0;
  endtask

  task automatic s_coin(input logic [1:0] code);
    s_coin_valid = 1'b1;
    s_coin_code = code;
    cyc(1);
    s_coin_valid = 1'b0;
  endtask

  task automatic dispense_seq(input string tg, input int amt, input bit poke);
    int k;
    chk({tg, "_credit"}, credit, amt);
    chk({tg, "_disp_early"}, dispense, 0);
    cyc(1);
    chk({tg, "_disp_on"}, dispense, 1);
    chk({tg, "_busy_on"}, busy, 1);
    if (poke) begin
      coin_valid = 1'b1;
      coin_code = 2'($urandom_range(0, 3));
      cyc(1);
      coin_valid = 1'b0;
      chk({tg, "_disp_reject"}, coin_reject, 1);
      chk({tg, "_disp_credit_hold"}, credit, amt);
    end
    k = 0;
    while (dispense && k < 40) begin
      cyc(1);
      k++;
    end
    chk({tg, "_disp_off"}, dispense, 0);
    chk({tg, "_disp_len_ok"}, k >= 6 && k <= 18, 1);
    chk({tg, "_chg_valid"}, change_valid, amt > PRICE);
    if (amt > PRICE) chk({tg, "_chg_amt"}, change_amt, amt - PRICE);
    chk({tg, "_credit_clr"}, credit, 0);
    chk({tg, "_busy_off"}, busy, 0);
    cyc(1);
    chk({tg, "_chg_pulse"}, change_valid, 0);
  endtask

  task automatic cancel_seq(input string tg, input int amt);
    cancel = 1'b1;
    cyc(1);
    cancel = 1'b0;
    chk({tg, "_refund_wait"}, change_valid, 0);
    chk({tg, "_refund_busy"}, busy, 1);
    cyc(1);
    chk({tg, "_refund_valid"}, change_valid, 1);
    chk({tg, "_refund_amt"}, change_amt, amt);
    chk({tg, "_refund_credit"}, credit, 0);
    chk({tg, "_refund_busy_off"}, busy, 0);
  endtask

  initial begin
    #2 rst = 1'b0;
    cyc(3);
    chk("rst_credit", credit, 0);
    chk("rst_dispense", dispense, 0);
    chk("rst_change_valid", change_valid, 0);
    chk("rst_change_amt", change_amt, 0);
    chk("rst_coin_reject", coin_reject, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    cyc(2);
    // exact price, no change, with a coin poked during dispense
    coin(2'd3);
    chk("p15_credit10", credit, 10);
    chk("p15_busy", busy, 1);
    chk("p15_reject", coin_reject, 0);
    coin(2'd2);
    dispense_seq("p15", 15, 1'b1);
    // overpay returns change
    coin(2'd3);
    coin(2'd3);
    dispense_seq("p20", 20, 1'b0);
    // cancel refunds accumulated credit
    coin(2'd2);
    coin(2'd0);
    chk("cxl_credit", credit, 6);
    cancel_seq("cxl", 6);
    // saturation on the MAX_CREDIT=20 instance
    s_coin(2'd3);
    s_coin(2'd1);
    s_coin(2'd1);
    chk("sat_credit14", s_credit, 14);
    s_coin(2'd3);
    chk("sat_reject", s_coin_reject, 1);
    chk("sat_credit_hold", s_credit, 14);
    cyc(1);
    chk("sat_reject_pulse", s_coin_reject, 0);
    s_cancel = 1'b1;
    cyc(1);
    s_cancel = 1'b0;
    cyc(1);
    chk("sat_refund", s_change_amt, 14);
`ifdef VEND_TIMEOUT_EN
    coin(2'd1);
    chk("to_credit", credit, 2);
    n = 0;
    while (!change_valid && n < 120) begin
      cyc(1);
      n++;
    end
    chk("to_refund", change_valid, 1);
    chk("to_amt", change_amt, 2);
    chk("to_busy", busy, 0);
    chk("to_window", n >= 70 && n <= 84, 1);
    cyc(1);
    coin(2'd0);
    repeat (8) @(posedge tick_in);
    cyc(1);
    chk("to9_busy8", busy, 1);
    @(posedge tick_in);
    coin_valid = 1'b1;
    coin_code = 2'd1;
    @(posedge clk_in);
    #1;
    coin_valid = 1'b0;
    chk("to9_credit", credit, 3);
    repeat (9) @(posedge tick_in);
    cyc(2);
    chk("to9_still_busy", busy, 1);
    chk("to9_no_refund", credit, 3);
    n = 0;
    while (!change_valid && n < 20) begin
      cyc(1);
      n++;
    end
    chk("to9_refund", change_valid, 1);
    chk("to9_amt", change_amt, 3);
`else
    coin(2'd1);
    repeat (12) @(posedge tick_in);
    cyc(2);
    chk("nto_busy", busy, 1);
    chk("nto_credit", credit, 2);
    cancel_seq("nto", 2);
`endif
    // asynchronous reset in the middle of dispense
    coin(2'd3);
    coin(2'd3);
    cyc(1);
    chk("rd_dispense_on", dispense, 1);
    cyc(2);
    rst = 1'b0;
    #1;
    chk("rd_dispense_off", dispense, 0);
    chk("rd_busy", busy, 0);
    chk("rd_credit", credit, 0);
    chk("rd_change_valid", change_valid, 0);
    cyc(1);
    rst = 1'b1;
    n = 0;
    repeat (30) begin
      cyc(1);
      if (change_valid) n++;
    end
    chk("rd_no_change", n, 0);
    coin(2'd2);
    chk("rd_post_credit", credit, 5);
    cancel_seq("rd_post", 5);
    // randomized transactions against the running-sum model
    for (int t = 0; t < 25; t++) begin
      total = 0;
      for (int k = 0; k < 8; k++) begin
        c = 2'($urandom_range(0, 3));
        cyc($urandom_range(0, 3));
        coin(c);
        total += vals[c];
        chk($sformatf("rnd%0d_credit", t), credit, total);
        chk($sformatf("rnd%0d_reject", t), coin_reject, 0);
        if (total >= PRICE || $urandom_range(0, 5) == 0) break;
      end
      if (total >= PRICE) dispense_seq($sformatf("rnd%0d", t), total, 1'($urandom_range(0, 1)));
      else cancel_seq($sformatf("rnd%0d", t), total);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
